// File: rtl/paddle_ctrl_if.sv
// rtl/paddle_ctrl_if.sv - paddle controller signal bundle (keyboard/ball inputs, paddle geometry outputs)
interface paddle_ctrl_if;
  logic [7:0] keycode;
  logic [9:0] BallY;
  logic [9:0] PaddleX;
  logic [9:0] PaddleY;
  logic [9:0] PaddleL;
  logic [9:0] PaddleW;
  logic [1:0] Dir;

  modport master (
    output keycode, BallY,
    input  PaddleX, PaddleY, PaddleL, PaddleW, Dir
  );

  modport slave (
    input  keycode, BallY,
    output PaddleX, PaddleY, PaddleL, PaddleW, Dir
  );
endinterface

// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - one paddle: accelerating vertical motion clamped to the playfield
// Optional macro CPU_TRACK_EN: request follows BallY instead of keycode.
module paddle_ctrl #(
  parameter int         PADDLE_X      = 40,
  parameter int         PADDLE_Y_INIT = 240,
  parameter int         PADDLE_HALF_L = 24,
  parameter int         PADDLE_HALF_W = 4,
  parameter int         Y_MIN         = 20,
  parameter int         Y_MAX         = 461,
  parameter int         STEP_MIN      = 2,
  parameter int         STEP_MAX      = 8,
  parameter int         ACCEL_FRAMES  = 4,
  parameter logic [7:0] KEY_UP        = 8'h1A,
  parameter logic [7:0] KEY_DOWN      = 8'h16,
  parameter int         DEADBAND      = 4
) (
  input  logic          Reset,
  input  logic          frame_clk,
  paddle_ctrl_if.slave  bus
);

  localparam int SW = $clog2(STEP_MAX + 1);
  localparam int CW = $clog2(ACCEL_FRAMES) + 1;
  localparam logic signed [10:0] Y_TOP = 11'(Y_MIN + PADDLE_HALF_L);
  localparam logic signed [10:0] Y_BOT = 11'(Y_MAX - PADDLE_HALF_L);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } state_t;

  state_t            state_q, state_d, req;
  logic [9:0]        y_q, y_d;
  logic [SW-1:0]     step_q, step_d, mv;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic signed [10:0] y_s, mv_s, y_up, y_dn;

  assign y_s = $signed({1'b0, y_q});

`ifdef CPU_TRACK_EN
  // 12-bit so BallY+DEADBAND near 1023 cannot overflow the compare.
  localparam logic signed [11:0] DB = 12'(DEADBAND);
  logic signed [11:0] ball_w, y_w;
  logic               unused_key;
  assign ball_w     = $signed({2'b00, bus.BallY});
  assign y_w        = $signed({2'b00, y_q});
  assign unused_key = ^bus.keycode;

  always_comb begin
    req = IDLE;
    if (ball_w + DB < y_w)      req = UP;
    else if (ball_w > y_w + DB) req = DOWN;
  end
`else
  logic unused_ball;
  assign unused_ball = ^bus.BallY;

  always_comb begin
    req = IDLE;
    if (bus.keycode == KEY_UP)        req = UP;
    else if (bus.keycode == KEY_DOWN) req = DOWN;
  end
`endif

  always_comb begin
    state_d = req;
    y_d     = y_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    mv      = step_q;
    if (req == IDLE) begin
      step_d = SW'(STEP_MIN);
      cnt_d  = '0;
    end else if (req != state_q) begin
      // entry or reversal restarts acceleration
      mv     = SW'(STEP_MIN);
      step_d = SW'(STEP_MIN);
      cnt_d  = CW'(1);
    end else if (cnt_q == CW'(ACCEL_FRAMES - 1)) begin
      cnt_d  = '0;
      step_d = (step_q >= SW'(STEP_MAX)) ? SW'(STEP_MAX) : step_q + 1'b1;
    end else begin
      cnt_d  = cnt_q + 1'b1;
    end
    mv_s = $signed({{(11 - SW){1'b0}}, mv});
    y_up = y_s - mv_s;
    y_dn = y_s + mv_s;
    if (req == UP)        y_d = (y_up < Y_TOP) ? Y_TOP[9:0] : y_up[9:0];
    else if (req == DOWN) y_d = (y_dn > Y_BOT) ? Y_BOT[9:0] : y_dn[9:0];
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      y_q     <= 10'(PADDLE_Y_INIT);
      step_q  <= SW'(STEP_MIN);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.PaddleX = 10'(PADDLE_X);
  assign bus.PaddleY = y_q;
  assign bus.PaddleL = 10'(PADDLE_HALF_L);
  assign bus.PaddleW = 10'(PADDLE_HALF_W);
  assign bus.Dir     = state_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb/tb_paddle_ctrl.sv - self-checking bench for paddle_ctrl (vector table, corner sequences, random vs model)
module tb_paddle_ctrl;
  logic Reset;
  logic frame_clk;
  paddle_ctrl_if bus();

  paddle_ctrl dut (
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .bus       (bus)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic [7:0] key;
    logic [9:0] ball;
    int         y;
    int         dir;
  } vec_t;

  vec_t tbl[$];

  int m_y, m_run, m_dir;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic chk_state(input string name, input int y, input int dir);
    chk({name, ".y"}, int'(bus.PaddleY), y);
    chk({name, ".dir"}, int'(bus.Dir), dir);
  endtask

  task automatic frame();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic async_reset();
    Reset = 1'b1;
    #1;
    chk("rst_px", int'(bus.PaddleX), 40);
    chk("rst_pl", int'(bus.PaddleL), 24);
    chk("rst_pw", int'(bus.PaddleW), 4);
    chk_state("rst", 240, 0);
    #1;
    Reset = 1'b0;
  endtask

  // Reference: step on frame n of a continuous run is STEP_MIN + (n-1)/ACCEL_FRAMES, capped.
  task automatic m_reset();
    m_y = 240;
    m_run = 0;
    m_dir = 0;
  endtask

  task automatic m_edge(input logic [7:0] key);
    int d, st;
    d = (key == 8'h1A) ? 1 : (key == 8'h16) ? 2 : 0;
    if (d == 0) m_run = 0;
    else if (d == m_dir) m_run++;
    else m_run = 1;
    st = (m_run > 0) ? 2 + (m_run - 1) / 4 : 2;
    if (st > 8) st = 8;
    if (d == 1) m_y = (m_y - st < 44) ? 44 : m_y - st;
    else if (d == 2) m_y = (m_y + st > 437) ? 437 : m_y + st;
    m_dir = d;
  endtask

  task automatic add(input logic r, input logic [7:0] k, input logic [9:0] b,
                     input int y, input int d);
    vec_t v;
    v.rst = r; v.key = k; v.ball = b; v.y = y; v.dir = d;
    tbl.push_back(v);
  endtask

  initial begin
    int peak, low;
    logic [7:0] key;
    int len, r;

    Reset = 1'b1;
    bus.keycode = 8'h00;
    bus.BallY = 10'd0;

`ifdef CPU_TRACK_EN
    add(1, 8'h16, 10'd242, 240, 0);
    add(0, 8'h16, 10'd242, 240, 0);
    add(0, 8'h16, 10'd100, 238, 1);
    add(0, 8'h16, 10'd100, 236, 1);
    add(0, 8'h16, 10'd100, 234, 1);
    add(0, 8'h16, 10'd100, 232, 1);
    add(0, 8'h16, 10'd100, 229, 1);
    add(0, 8'h16, 10'd230, 229, 0);
    add(0, 8'h16, 10'd230, 229, 0);
    add(0, 8'h1A, 10'd300, 231, 2);
`else
    add(1, 8'h00, 10'd0, 240, 0);
    add(0, 8'h00, 10'd0, 240, 0);
    add(0, 8'h00, 10'd0, 240, 0);
    add(0, 8'h00, 10'd0, 240, 0);
    add(0, 8'h1A, 10'd0, 238, 1);
    add(0, 8'h1A, 10'd0, 236, 1);
    add(0, 8'h1A, 10'd0, 234, 1);
    add(0, 8'h1A, 10'd0, 232, 1);
    add(0, 8'h1A, 10'd0, 229, 1);
    add(0, 8'h1A, 10'd0, 226, 1);
    add(0, 8'h1A, 10'd0, 223, 1);
    add(0, 8'h1A, 10'd0, 220, 1);
    add(0, 8'h16, 10'd0, 222, 2);
    add(0, 8'h00, 10'd0, 222, 0);
    add(0, 8'h00, 10'd0, 222, 0);
    add(0, 8'h16, 10'd0, 224, 2);
    add(0, 8'h55, 10'd999, 224, 0);
    add(1, 8'h00, 10'd0, 240, 0);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      bus.keycode = tbl[i].key;
      bus.BallY = tbl[i].ball;
      if (tbl[i].rst) async_reset();
      else frame();
      chk_state($sformatf("vec%0d", i), tbl[i].y, tbl[i].dir);
    end

`ifndef CPU_TRACK_EN
    // Clamp at the bottom, then at the top.
    async_reset();
    bus.keycode = 8'h16;
    peak = 0;
    for (int i = 0; i < 60; i++) begin
      frame();
      if (int'(bus.PaddleY) > peak) peak = int'(bus.PaddleY);
    end
    chk("clamp_dn_peak", peak, 437);
    chk_state("clamp_dn", 437, 2);
    bus.keycode = 8'h1A;
    low = 1023;
    for (int i = 0; i < 60; i++) begin
      frame();
      if (int'(bus.PaddleY) < low) low = int'(bus.PaddleY);
    end
    chk("clamp_up_low", low, 44);
    chk_state("clamp_up", 44, 1);

    // Reset mid-move acts without a clock edge and restarts acceleration.
    async_reset();
    bus.keycode = 8'h1A;
    for (int i = 0; i < 6; i++) frame();
    chk_state("mid_move", 226, 1);
    async_reset();
    frame();
    chk_state("after_rst", 238, 1);

    // Random bursts against the reference model.
    async_reset();
    m_reset();
    for (int b = 0; b < 60; b++) begin
      r = $urandom_range(0, 9);
      if (r < 4) key = 8'h1A;
      else if (r < 8) key = 8'h16;
      else if (r == 8) key = 8'h00;
      else key = 8'($urandom_range(0, 255));
      len = $urandom_range(1, 20);
      bus.keycode = key;
      if ($urandom_range(0, 19) == 0) begin
        async_reset();
        m_reset();
      end
      for (int j = 0; j < len; j++) begin
        frame();
        m_edge(key);
        chk_state($sformatf("rnd%0d_%0d", b, j), m_y, m_dir);
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
